// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register address width and forwarding tap record
package cpu_types;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CPU_XLEN   = 32;

    // One forwarding tap: the destination register, its value and whether the value is ready.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] address;
        logic [CPU_XLEN-1:0]   data;
        logic                  valid;
    } fwd_stage_t;

endpackage

// File: rtl/forwarding_scoreboard_if.sv
// rtl/forwarding_scoreboard_if.sv - operand/tap/issue/retire bundle between pipeline and scoreboard
interface forwarding_scoreboard_if
    import cpu_types::*;
#(
    parameter int READ_PORTS = 2,
    parameter int STAGES     = 3,
    parameter int XLEN       = 32
) ();

    logic [READ_PORTS-1:0][REG_ADDR_W-1:0] read_address;
    logic [READ_PORTS-1:0][XLEN-1:0]       register_file_data;
    fwd_stage_t [STAGES-1:0]               stage_taps;
    logic                                  issue_valid;
    logic [REG_ADDR_W-1:0]                 issue_address;
    logic                                  retire_valid;
    logic [REG_ADDR_W-1:0]                 retire_address;
    logic                                  flush;
    logic [READ_PORTS-1:0][XLEN-1:0]       data;
    logic [READ_PORTS-1:0]                 forwarding;
    logic                                  stall;
    logic                                  underflow_err;
    logic [31:0]                           stall_cycles;
    logic [31:0]                           fwd_hits;

    modport master (
        output read_address, register_file_data, stage_taps,
        output issue_valid, issue_address, retire_valid, retire_address, flush,
        input  data, forwarding, stall, underflow_err, stall_cycles, fwd_hits
    );

    modport slave (
        input  read_address, register_file_data, stage_taps,
        input  issue_valid, issue_address, retire_valid, retire_address, flush,
        output data, forwarding, stall, underflow_err, stall_cycles, fwd_hits
    );

endinterface

// File: rtl/forwarding_scoreboard_port_resolve.sv
// rtl/forwarding_scoreboard_port_resolve.sv - per-read-port operand resolution (tap priority, then scoreboard)
module fwd_port_resolve
    import cpu_types::*;
#(
    parameter int STAGES = 3,
    parameter int XLEN   = 32
) (
    input  logic [REG_ADDR_W-1:0] read_address,
    input  logic [XLEN-1:0]       register_file_data,
    input  fwd_stage_t [STAGES-1:0] stage_taps,
    input  logic [NUM_REGS-1:0]   pending,
    output logic [XLEN-1:0]       data,
    output logic                  forwarding,
    output logic                  stall
);

    logic found;

    // Youngest matching tap wins; an unready tap stalls; otherwise an in-flight writer stalls.
    always_comb begin
        data       = register_file_data;
        forwarding = 1'b0;
        stall      = 1'b0;
        found      = 1'b0;
        if (read_address != '0) begin
            for (int s = 0; s < STAGES; s++) begin
                if (!found && stage_taps[s].address == read_address) begin
                    found      = 1'b1;
                    data       = stage_taps[s].data[XLEN-1:0];
                    forwarding = 1'b1;
                    stall      = !stage_taps[s].valid;
                end
            end
            if (!found) begin
                stall = pending[read_address];
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - operand forwarding and pending-writer scoreboard; optional FWD_PERF_COUNTERS_EN
module forwarding_scoreboard
    import cpu_types::*;
#(
    parameter int READ_PORTS = 2,
    parameter int STAGES     = 3,
    parameter int XLEN       = 32
) (
    input logic clk,
    input logic rst_n,
    forwarding_scoreboard_if.slave bus
);

    localparam int CNT_W = $clog2(STAGES + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]            pending_count [NUM_REGS-1:1];
    logic [NUM_REGS-1:0]         pending;
    logic                        underflow_q;
    logic [READ_PORTS-1:0][XLEN-1:0] port_data;
    logic [READ_PORTS-1:0]       port_fwd;
    logic [READ_PORTS-1:0]       port_stall;
    logic                        stall_all;

    // Register 0 is hardwired, so it never has an outstanding writer.
    always_comb begin
        pending[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending[r] = (pending_count[r] != '0);
        end
    end

    genvar p;
    generate
        for (p = 0; p < READ_PORTS; p++) begin : g_port
            fwd_port_resolve #(.STAGES(STAGES), .XLEN(XLEN)) u_resolve (
                .read_address       (bus.read_address[p]),
                .register_file_data (bus.register_file_data[p]),
                .stage_taps         (bus.stage_taps),
                .pending            (pending),
                .data               (port_data[p]),
                .forwarding         (port_fwd[p]),
                .stall              (port_stall[p])
            );
        end
    endgenerate

    assign stall_all         = |port_stall;
    assign bus.data          = port_data;
    assign bus.forwarding    = port_fwd;
    assign bus.stall         = stall_all;
    assign bus.underflow_err = underflow_q;

    // Pending-writer counters: issue increments (blocked while stalled), retire decrements, flush clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                pending_count[r] <= '0;
            end
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                pending_count[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.issue_valid && !stall_all && bus.issue_address == REG_ADDR_W'(r)) begin
                    if (!(bus.retire_valid && bus.retire_address == REG_ADDR_W'(r))
                        && pending_count[r] != CNT_MAX) begin
                        pending_count[r] <= pending_count[r] + CNT_ONE;
                    end
                end else if (bus.retire_valid && bus.retire_address == REG_ADDR_W'(r)) begin
                    if (pending_count[r] == '0) begin
                        underflow_q <= 1'b1;
                    end else begin
                        pending_count[r] <= pending_count[r] - CNT_ONE;
                    end
                end
            end
        end
    end

`ifdef FWD_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] fwd_hits_q;

    // Saturating counts of stalled cycles and of cycles served by forwarding without a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            fwd_hits_q     <= '0;
        end else begin
            if (stall_all && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (|port_fwd && !stall_all && fwd_hits_q != 32'hFFFF_FFFF) begin
                fwd_hits_q <= fwd_hits_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.fwd_hits     = fwd_hits_q;
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.fwd_hits     = 32'd0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - directed self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;
    import cpu_types::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] RF0 = 32'h1111_0000;
    localparam logic [31:0] RF1 = 32'h2222_0000;

    forwarding_scoreboard_if #(.READ_PORTS(2), .STAGES(3), .XLEN(32)) bus ();

    forwarding_scoreboard #(.READ_PORTS(2), .STAGES(3), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are then changed 2ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_taps();
        for (int s = 0; s < 3; s++) begin
            bus.stage_taps[s] = '0;
        end
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus.read_address       = '0;
        bus.register_file_data = '0;
        clear_taps();
        bus.issue_valid        = 1'b0;
        bus.issue_address      = '0;
        bus.retire_valid       = 1'b0;
        bus.retire_address     = '0;
        bus.flush              = 1'b0;
        #1;
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_underflow", 64'(bus.underflow_err), 64'd0);
        chk("reset_stall_cycles", 64'(bus.stall_cycles), 64'd0);
        chk("reset_fwd_hits", 64'(bus.fwd_hits), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.register_file_data[0] = RF0;
        bus.register_file_data[1] = RF1;

        // Youngest tap wins
        bus.read_address[0] = 5'd5;
        bus.stage_taps[0]   = '{address: 5'd5, data: 32'hAAAA_0001, valid: 1'b1};
        bus.stage_taps[1]   = '{address: 5'd5, data: 32'h0000_BBBB, valid: 1'b1};
        #1;
        chk("tap_prio_data", 64'(bus.data[0]), 64'h0000_0000_AAAA_0001);
        chk("tap_prio_fwd", 64'(bus.forwarding), 64'b01);
        chk("tap_prio_stall", 64'(bus.stall), 64'd0);
        chk("port1_x0_data", 64'(bus.data[1]), 64'(RF1));
        clear_taps();

        // x0 never forwards, even from a tap addressed to 0
        bus.read_address[0] = 5'd0;
        bus.stage_taps[0]   = '{address: 5'd0, data: 32'hDEAD_BEEF, valid: 1'b1};
        #1;
        chk("x0_data", 64'(bus.data[0]), 64'(RF0));
        chk("x0_fwd", 64'(bus.forwarding), 64'd0);
        chk("x0_stall", 64'(bus.stall), 64'd0);
        clear_taps();

        // Issue x7, read it on port 1 until it retires
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd7;
        tick();
        bus.issue_valid     = 1'b0;
        bus.read_address[1] = 5'd7;
        #1;
        chk("x7_stall", 64'(bus.stall), 64'd1);
        chk("x7_stall_data", 64'(bus.data[1]), 64'(RF1));
        chk("x7_stall_fwd", 64'(bus.forwarding), 64'd0);
        // Issue while stalled must be dropped
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd10;
        tick();
        bus.issue_valid = 1'b0;
        #1;
        chk("x7_still_stall", 64'(bus.stall), 64'd1);
        bus.retire_valid   = 1'b1;
        bus.retire_address = 5'd7;
        #1;
        chk("x7_retire_cycle_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.retire_valid = 1'b0;
        #1;
        chk("x7_released", 64'(bus.stall), 64'd0);
        chk("x7_released_data", 64'(bus.data[1]), 64'(RF1));
        bus.read_address[1] = 5'd10;
        #1;
        chk("x10_issue_dropped", 64'(bus.stall), 64'd0);
        bus.read_address[1] = 5'd0;

        // Same-cycle issue and retire of x11 leaves its count at 0, with no underflow
        bus.issue_valid    = 1'b1;
        bus.issue_address  = 5'd11;
        bus.retire_valid   = 1'b1;
        bus.retire_address = 5'd11;
        tick();
        bus.issue_valid  = 1'b0;
        bus.retire_valid = 1'b0;
        bus.read_address[1] = 5'd11;
        #1;
        chk("x11_same_cycle", 64'(bus.stall), 64'd0);
        chk("x11_no_underflow", 64'(bus.underflow_err), 64'd0);
        bus.read_address[1] = 5'd0;

        // x3: two issues, retires drain then underflow
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd3;
        tick();
        tick();
        bus.issue_valid    = 1'b0;
        bus.retire_valid   = 1'b1;
        bus.retire_address = 5'd3;
        tick();
        bus.retire_valid    = 1'b0;
        bus.read_address[0] = 5'd3;
        #1;
        chk("x3_count1_stall", 64'(bus.stall), 64'd1);
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        #1;
        chk("x3_count0_nostall", 64'(bus.stall), 64'd0);
        chk("x3_no_underflow_yet", 64'(bus.underflow_err), 64'd0);
        bus.retire_valid = 1'b1;
        tick();
        bus.retire_valid = 1'b0;
        #1;
        chk("x3_underflow", 64'(bus.underflow_err), 64'd1);
        chk("x3_count_stays0", 64'(bus.stall), 64'd0);
        tick();
        tick();
        chk("x3_underflow_sticky", 64'(bus.underflow_err), 64'd1);
        bus.read_address[0] = 5'd0;

        // Flush wins over a same-cycle issue
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd9;
        bus.flush         = 1'b1;
        tick();
        bus.issue_valid     = 1'b0;
        bus.flush           = 1'b0;
        bus.read_address[0] = 5'd9;
        #1;
        chk("x9_flush_count0", 64'(bus.stall), 64'd0);
        bus.stage_taps[2] = '{address: 5'd9, data: 32'h0000_0099, valid: 1'b0};
        #1;
        chk("x9_tap_stall", 64'(bus.stall), 64'd1);
        chk("x9_tap_fwd", 64'(bus.forwarding), 64'b01);
        chk("x9_tap_data", 64'(bus.data[0]), 64'h99);
        clear_taps();
        bus.read_address[0] = 5'd0;

        // Flush clears an already pending writer
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd12;
        tick();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b1;
        tick();
        bus.flush           = 1'b0;
        bus.read_address[0] = 5'd12;
        #1;
        chk("x12_flushed", 64'(bus.stall), 64'd0);
        bus.read_address[0] = 5'd0;

        // Reset discards pending writers and the sticky error
        bus.issue_valid   = 1'b1;
        bus.issue_address = 5'd15;
        tick();
        bus.issue_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_underflow_clear", 64'(bus.underflow_err), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.read_address[0] = 5'd15;
        #1;
        chk("rst_pending_cleared", 64'(bus.stall), 64'd0);

        // Four stalled cycles from an unready tap, then reset mid-stall
        bus.read_address[0] = 5'd4;
        bus.stage_taps[0]   = '{address: 5'd4, data: 32'h0000_0044, valid: 1'b0};
        #1;
        chk("perf_stall_on", 64'(bus.stall), 64'd1);
        tick();
        tick();
        tick();
        tick();
`ifdef FWD_PERF_COUNTERS_EN
        chk("perf_stall_cycles_4", 64'(bus.stall_cycles), 64'd4);
`else
        chk("perf_stall_cycles_off", 64'(bus.stall_cycles), 64'd0);
`endif
        chk("perf_fwd_hits_0", 64'(bus.fwd_hits), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("perf_stall_cycles_rst", 64'(bus.stall_cycles), 64'd0);
        chk("perf_fwd_hits_rst", 64'(bus.fwd_hits), 64'd0);
        tick();
        rst_n = 1'b1;

        // One non-stalled forwarding cycle
        bus.stage_taps[0] = '{address: 5'd4, data: 32'h0000_0044, valid: 1'b1};
        #1;
        chk("hit_fwd_data", 64'(bus.data[0]), 64'h44);
        tick();
`ifdef FWD_PERF_COUNTERS_EN
        chk("perf_fwd_hits_1", 64'(bus.fwd_hits), 64'd1);
`else
        chk("perf_fwd_hits_off", 64'(bus.fwd_hits), 64'd0);
`endif
        chk("perf_no_stall_count", 64'(bus.stall_cycles), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
